// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared definitions for the icache refill responder: refill
//               FSM state encodings, beat size, and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

  localparam int BEAT_BYTES = 8;

  // State encodings, used as plain localparams by the FSM.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  typedef enum logic [1:0] {
    REFILL_IDLE  = 2'd0,
    REFILL_ISSUE = 2'd1,
    REFILL_DRAIN = 2'd2,
    REFILL_ERR   = 2'd3
  } refill_state_e;

  // Number of 64-bit beats in a cache line.
  function automatic int beat_count(input int line_bytes);
    return line_bytes / BEAT_BYTES;
  endfunction

  // Index width for n items; never narrower than one bit.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/refill_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : refill_skid_fifo
// Description : Two-entry FIFO holding {error, data} response beats.
//               Ports: i_push/i_wdata write side, i_pop/o_rdata read side,
//               o_count occupancy (0..2). A pop on an empty FIFO is ignored;
//               the producer never pushes into a full FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module refill_skid_fifo #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [1:0]       o_count
);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  w_pop_eff;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    w_pop_eff = i_pop && (count_q != 2'd0);
    if (i_push) begin
      mem_d[wr_ptr_q] = i_wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (w_pop_eff) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, i_push} - {1'b0, w_pop_eff};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/icache_refill_responder.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_responder
// Description : Serves icache line refills from word-interleaved banked SRAM,
//               returning the line critical-word-first as 64-bit beats.
//               Ports: i_req_* refill request (valid/ready, addr, rd, wr,
//               data ignored); o_res_*/i_res_ready beat stream (valid, ready,
//               error, data); o_mem_*/i_mem_dout SRAM port (one-hot bank
//               enables, row address, we/din tied low, 1-cycle read data).
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_responder
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int LINE_BYTES     = 32,
  parameter int NUM_BANKS      = 4,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_req_valid,
  output logic                                 o_req_ready,
  input  logic [ADDR_WIDTH-1:0]                i_req_addr,
  input  logic                                 i_req_rd,
  input  logic                                 i_req_wr,
  input  logic [DATA_WIDTH-1:0]                i_req_data,
  output logic                                 o_res_valid,
  input  logic                                 i_res_ready,
  output logic                                 o_res_error,
  output logic [DATA_WIDTH-1:0]                o_res_data,
  output logic [NUM_BANKS-1:0]                 o_mem_en,
  output logic                                 o_mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]            o_mem_addr,
  output logic [DATA_WIDTH-1:0]                o_mem_din,
  input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] i_mem_dout
);

  localparam int BEATS  = beat_count(LINE_BYTES);
  localparam int BEAT_W = index_width(BEATS);
  localparam int BANK_W = index_width(NUM_BANKS);
  // Word-index bits that map onto SRAM; anything above is out of range.
  localparam int WORD_W = BANK_W + MEM_ADDR_WIDTH;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [1:0]              state_q, state_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [BEAT_W-1:0]       cnt_q, cnt_d;
  logic                    infl_valid_q, infl_valid_d;
  logic [BANK_W-1:0]       infl_bank_q, infl_bank_d;

  logic                    w_req_err;
  logic [WORD_W-1:0]       w_word;
  logic [BANK_W-1:0]       w_bank;
  logic                    w_issue;
  logic                    w_err_push;
  logic                    w_push;
  logic [DATA_WIDTH:0]     w_wdata;
  logic [DATA_WIDTH:0]     w_rdata;
  logic [1:0]              w_count;
  logic                    w_fifo_valid;
  logic                    w_pop;
  logic [2:0]              w_level;
  logic                    w_room;
  logic                    w_unused;

  assign w_unused = ^{i_req_data, i_req_addr[2:0]};

  assign w_req_err = i_req_wr || !i_req_rd || (|i_req_addr[ADDR_WIDTH-1:3+WORD_W]);

  // Critical-word-first: only the in-line beat bits advance, wrapping in the line.
  assign w_word = {word_q[WORD_W-1:BEAT_W], word_q[BEAT_W-1:0] + cnt_q};
  assign w_bank = w_word[BANK_W-1:0];

  assign w_fifo_valid = (w_count != 2'd0);
  assign w_pop        = w_fifo_valid && i_res_ready;

  // Slots committed after this cycle's pop; a new beat may start only if one
  // slot remains, so the FIFO can never be asked to hold a third entry.
  assign w_level = {1'b0, w_count} + {2'b00, infl_valid_q} - {2'b00, w_pop};
  assign w_room  = (w_level < 3'd2);

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    infl_valid_d = 1'b0;
    infl_bank_d  = infl_bank_q;
    w_issue      = 1'b0;
    w_err_push   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          word_d  = i_req_addr[3 +: WORD_W];
          cnt_d   = '0;
          state_d = w_req_err ? ST_ERR : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_room) begin
          w_issue      = 1'b1;
          infl_valid_d = 1'b1;
          infl_bank_d  = w_bank;
          cnt_d        = cnt_q + BEAT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_ERR: begin
        if (w_room) begin
          w_err_push = 1'b1;
          cnt_d      = cnt_q + BEAT_W'(1);
          // The error tail waits for its last handshake exactly as a read does.
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Nothing left in flight and the sole remaining beat leaves now.
        if (!infl_valid_q && (w_count == 2'd1) && w_pop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      cnt_q        <= '0;
      infl_valid_q <= 1'b0;
      infl_bank_q  <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      infl_valid_q <= infl_valid_d;
      infl_bank_q  <= infl_bank_d;
    end
  end

  assign w_push  = infl_valid_q || w_err_push;
  assign w_wdata = infl_valid_q ? {1'b0, i_mem_dout[infl_bank_q]}
                                : {1'b1, {DATA_WIDTH{1'b0}}};

  refill_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_count)
  );

  // Outputs are forced quiet while rst is high, independent of flop contents.
  assign o_req_ready = (state_q == ST_IDLE) && !rst;
  assign o_res_valid = w_fifo_valid && !rst;
  assign o_res_error = rst ? 1'b0 : w_rdata[DATA_WIDTH];
  assign o_res_data  = rst ? '0 : w_rdata[DATA_WIDTH-1:0];
  assign o_mem_en    = (w_issue && !rst) ? (NUM_BANKS'(1) << w_bank) : '0;
  assign o_mem_addr  = (w_issue && !rst) ? w_word[WORD_W-1:BANK_W] : '0;
  assign o_mem_we    = 1'b0;
  assign o_mem_din   = '0;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill_responder
// Description : Directed self-checking bench for icache_refill_responder.
//               SRAM model returns word index i for word i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_responder;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_addr = '0;
  logic             req_rd = 1'b0;
  logic             req_wr = 1'b0;
  logic [63:0]      req_data = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             res_error;
  logic [63:0]      res_data;
  logic [3:0]       mem_en;
  logic             mem_we;
  logic [9:0]       mem_addr;
  logic [63:0]      mem_din;
  logic [3:0][63:0] mem_dout = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0, t_idle, t_rdy;
  int n_issued, n_deliv;
  logic hs, prev_stall;
  logic [63:0] prev_data;
  logic prev_err;

  logic [63:0] got_data[$];
  logic        got_err[$];
  int          got_cyc[$];
  logic [3:0]  en_log[$];
  logic [9:0]  addr_log[$];
  int          en_cyc[$];
  logic        rdy_q[$];

  icache_refill_responder dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_rd    (req_rd),
    .i_req_wr    (req_wr),
    .i_req_data  (req_data),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_error (res_error),
    .o_res_data  (res_data),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_din   (mem_din),
    .i_mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;

  // SRAM model: word index = row*4 + bank, content = word index.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_en[b]) mem_dout[b] <= 64'(mem_addr) * 64'd4 + 64'(b);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply next res_ready, then sample and log outputs.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rdy_q.size() > 0) res_ready = rdy_q.pop_front();
    #1;
    cyc++;
    hs = res_valid && res_ready;
    if (prev_stall) begin
      chk("stall_valid", {63'd0, res_valid}, 64'd1);
      chk("stall_data", res_data, prev_data);
      chk("stall_error", {63'd0, res_error}, {63'd0, prev_err});
    end
    if (mem_en != 4'd0) begin
      chk("issue_room", {63'd0, (n_issued - n_deliv - (hs ? 1 : 0)) < 2}, 64'd1);
      en_log.push_back(mem_en);
      addr_log.push_back(mem_addr);
      en_cyc.push_back(cyc);
      n_issued++;
    end
    if (hs) begin
      got_data.push_back(res_data);
      got_err.push_back(res_error);
      got_cyc.push_back(cyc);
      n_deliv++;
    end
    prev_stall = res_valid && !res_ready;
    prev_data  = res_data;
    prev_err   = res_error;
  endtask

  task automatic clear_logs();
    got_data.delete(); got_err.delete(); got_cyc.delete();
    en_log.delete(); addr_log.delete(); en_cyc.delete();
    n_issued = 0; n_deliv = 0; prev_stall = 1'b0;
  endtask

  // Present a request in the current cycle (T), check it is accepted.
  task automatic present(input logic [31:0] a, input logic rd, input logic wr);
    clear_logs();
    req_valid = 1'b1; req_addr = a; req_rd = rd; req_wr = wr;
    t0 = cyc;
    chk("accept_ready", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      if (req_ready) break;
    end
    chk("idle_timeout", {63'd0, req_ready}, 64'd1);
    t_idle = cyc;
  endtask

  task automatic check_beats(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                             input logic [63:0] e2, input logic [63:0] e3, input logic e_err);
    logic [63:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    chk({tag, "_count"}, 64'(got_data.size()), 64'd4);
    if (got_data.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s_data%0d", tag, i), got_data[i], exp[i]);
        chk($sformatf("%s_err%0d", tag, i), {63'd0, got_err[i]}, {63'd0, e_err});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state while rst is high ----
    @(posedge clk); #2;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_res_error", {63'd0, res_error}, 64'd0);
    chk("rst_mem_en", {60'd0, mem_en}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_addr", {54'd0, mem_addr}, 64'd0);
    chk("rst_mem_din", mem_din, 64'd0);
    rst = 1'b0;
    cycle();
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("post_rst_res_valid", {63'd0, res_valid}, 64'd0);

    // ---- aligned read 0x40 ----
    present(32'h40, 1'b1, 1'b0);
    cycle(); req_valid = 1'b0;
    chk("al_busy", {63'd0, req_ready}, 64'd0);
    wait_idle(20);
    check_beats("al", 64'd8, 64'd9, 64'd10, 64'd11, 1'b0);
    if (got_cyc.size() >= 4) begin
      chk("al_first_beat_cyc", 64'(got_cyc[0]), 64'(t0 + 3));
      chk("al_last_beat_cyc", 64'(got_cyc[3]), 64'(t0 + 6));
    end
    if (en_cyc.size() >= 1) chk("al_first_en_cyc", 64'(en_cyc[0]), 64'(t0 + 1));
    chk("al_idle_cyc", 64'(t_idle), 64'(t0 + 7));

    // ---- wrap read 0x58 ----
    present(32'h58, 1'b1, 1'b0);
    cycle(); req_valid = 1'b0;
    wait_idle(20);
    check_beats("wr", 64'd11, 64'd8, 64'd9, 64'd10, 1'b0);
    chk("wr_en_count", 64'(en_log.size()), 64'd4);
    if (en_log.size() >= 4) begin
      chk("wr_en0", {60'd0, en_log[0]}, 64'h8);
      chk("wr_en1", {60'd0, en_log[1]}, 64'h1);
      chk("wr_en2", {60'd0, en_log[2]}, 64'h2);
      chk("wr_en3", {60'd0, en_log[3]}, 64'h4);
      for (int i = 0; i < 4; i++) chk($sformatf("wr_row%0d", i), {54'd0, addr_log[i]}, 64'd2);
    end

    // ---- backpressure 0x40, ready 1,0,0,1,0,1,1 from the first beat ----
    present(32'h40, 1'b1, 1'b0);
    rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    cycle(); req_valid = 1'b0;
    wait_idle(30);
    check_beats("bp", 64'd8, 64'd9, 64'd10, 64'd11, 1'b0);
    chk("bp_en_count", 64'(en_log.size()), 64'd4);
    res_ready = 1'b1;

    // ---- error: out-of-range address ----
    present(32'h0000_8000, 1'b1, 1'b0);
    cycle(); req_valid = 1'b0;
    wait_idle(20);
    check_beats("er1", 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
    chk("er1_no_mem", 64'(en_log.size()), 64'd0);
    if (got_cyc.size() >= 1) chk("er1_first_beat_cyc", 64'(got_cyc[0]), 64'(t0 + 2));

    // ---- error: write request ----
    present(32'h40, 1'b0, 1'b1);
    cycle(); req_valid = 1'b0;
    wait_idle(20);
    check_beats("er2", 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
    chk("er2_no_mem", 64'(en_log.size()), 64'd0);

    // ---- reset mid-burst after beat 2 handshakes ----
    present(32'h58, 1'b1, 1'b0);
    cycle(); req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (got_data.size() >= 2) break;
      cycle();
    end
    chk("mid_two_beats", 64'(got_data.size()), 64'd2);
    cycle();
    rst = 1'b1;
    #1;
    chk("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("mid_after_res_valid", {63'd0, res_valid}, 64'd0);
    chk("mid_after_res_data", res_data, 64'd0);
    chk("mid_after_res_error", {63'd0, res_error}, 64'd0);
    chk("mid_after_mem_en", {60'd0, mem_en}, 64'd0);
    chk("mid_after_mem_addr", {54'd0, mem_addr}, 64'd0);
    cycle();
    chk("mid_idle_ready", {63'd0, req_ready}, 64'd1);
    present(32'h58, 1'b1, 1'b0);
    cycle(); req_valid = 1'b0;
    wait_idle(20);
    check_beats("mid", 64'd11, 64'd8, 64'd9, 64'd10, 1'b0);

    // ---- back-to-back: second request held from T+1 ----
    present(32'h40, 1'b1, 1'b0);
    cycle();
    req_addr = 32'h20;
    t_rdy = -1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        t_rdy = cyc;
        break;
      end
      cycle();
    end
    chk("b2b_ready_cyc", 64'(t_rdy), 64'(t0 + 7));
    check_beats("b2b1", 64'd8, 64'd9, 64'd10, 64'd11, 1'b0);
    if (got_cyc.size() >= 4) chk("b2b1_last_beat", 64'(got_cyc[3]), 64'(t_rdy - 1));
    // second request is accepted at the end of this cycle
    clear_logs();
    t0 = cyc;
    cycle(); req_valid = 1'b0;
    wait_idle(20);
    check_beats("b2b2", 64'd4, 64'd5, 64'd6, 64'd7, 1'b0);
    if (got_cyc.size() >= 1) chk("b2b2_first_beat", 64'(got_cyc[0]), 64'(t0 + 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_refill_responder.md
# icache_refill_responder

Memory-side responder for instruction-cache line refills. Accepts refill requests from the icache controller on a `data_req_if.in` port and reads the line from banked on-chip SRAM through a `mem_if.master` port. Returns the line critical-word-first as 64-bit beats on a `data_res_if.out` port. Sits between the icache controller's refill path and the instruction SRAM. It is the serving end of the controller's request/result handshake.

## Interface
- `AddrWidth`, 32: request address width (byte address).
- `DataWidth`, 64: beat width; fixed at 64 (8 bytes/beat).
- `LineBytes`, 32: cache line size; `Beats = LineBytes/8` (default 4).
- `NumBanks`, 4: SRAM banks, word-interleaved.
- `MemAddrWidth`, 10: SRAM row address width.
- `clk` in 1: clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `req` `data_req_if.in`: refill request.
  - `valid`/`ready`: handshake.
  - `addr`: byte address of the critical word.
  - `rd`/`wr`: operation.
  - `data`: ignored.
- `res` `data_res_if.out`: beat stream (`valid`, `ready`, `error`, `data[63:0]`).
- `mem` `mem_if.master`: SRAM port.
  - `en[NumBanks]`: bank enables.
  - `we`: always 0.
  - `addr[MemAddrWidth]`: row address.
  - `din`: always 0.
  - `dout[NumBanks]`: read data, 1-cycle latency.

## Operation
- Word index `w = addr[AddrWidth-1:3]`. Bank `= w mod NumBanks`. Row `= w >> log2(NumBanks)`.
- Line base `= w` with its low `log2(Beats)` bits cleared. Beat k reads word `base | ((w + k) mod Beats)`: critical word first, wrapping within the line.
- Error request: `wr=1`, or `rd=0`, or any `addr` bit at or above `3+log2(NumBanks)+MemAddrWidth` set.
  - Response is `Beats` beats with `error=1` and `data=0`.
  - No SRAM access is made.
- FSM states:
  - IDLE: `req.ready=1`. On `valid&&ready`, latch `addr`. Go to ERR if error request, else ISSUE.
  - ISSUE: issue one SRAM read per cycle while (FIFO occupancy + in-flight) < 2. Beat counter `0..Beats-1`. After issuing beat `Beats-1`, go to DRAIN.
  - DRAIN: wait until the last beat handshakes on `res`, then go to IDLE.
  - ERR: push `Beats` error beats into the FIFO, subject to the same occupancy rule. After the last error beat handshakes, go to IDLE.
- Read issue drives a one-hot `mem.en`, `mem.addr = row`, and `mem.we = 0`.
- The cycle after a read issue, `mem.dout[bank]` is written into a 2-entry FIFO. The bank index is carried in a 1-deep in-flight register.
- `res.valid` = FIFO non-empty. `res.data` and `res.error` = FIFO head. A beat is consumed on `res.valid && res.ready`.
- The FIFO never overflows and no beat is dropped or duplicated under any `res.ready` pattern.
- `req.ready` is 0 in all states except IDLE. A request held during a burst is accepted only after the FSM returns to IDLE.

## Timing
- Reset values, both while `rst` is high and on the cycle after it:
  - `req.ready=0` while `rst` is high; 1 from the first cycle after `rst` falls.
  - `res.valid=0`, `res.error=0`, `res.data=0`.
  - `mem.en=0`, `mem.we=0`, `mem.addr=0`, `mem.din=0`.
  - FSM in IDLE; FIFO, in-flight register and counter cleared.
- Accept at cycle T:
  - First `mem.en` at T+1.
  - First `res.valid` at T+3.
  - With `res.ready=1` held, one beat per cycle; last beat at T+2+Beats.
- Error request accepted at T: first error beat at T+2, then one per cycle.
- Return to IDLE: the cycle after the final beat handshake. `req.ready=1` on that cycle, so a new request can be accepted there.
- `rst` mid-burst: on the next cycle all state and outputs are at reset values. In-flight SRAM data is discarded and no stale beat is ever presented.
- Backpressure: `res.data` and `res.error` are stable while `res.valid && !res.ready`.

## Structure
- Shared package `icache_pkg` holds:
  - the `refill_state_e` enum (IDLE, ISSUE, DRAIN, ERR);
  - `BEAT_BYTES = 8`;
  - the beat-count and bank-index width helpers.
- One sub-module: `refill_skid_fifo`, a 2-entry FIFO of `{error, data[63:0]}` with push/pop/occupancy.
- Top level holds the FSM, address generation, beat counter and in-flight register.

## Test plan
- Aligned read at `addr=0x40`, SRAM word i preloaded with `i`, `res.ready=1`:
  - beats 8, 9, 10, 11 at T+3..T+6;
  - `error=0`;
  - `req.ready` back to 1 at T+7.
- Wrap read at `addr=0x58`: beats 11, 8, 9, 10.
  - Banks enabled in order 3, 0, 1, 2.
  - Row 2 on every `mem.en` cycle.
- Backpressure, `addr=0x40`, `res.ready` pattern 1,0,0,1,0,1,1:
  - exactly 8, 9, 10, 11 delivered, each exactly once;
  - data stable during stalls;
  - `mem.en` never asserted when occupancy + in-flight = 2.
- Error requests: `addr=0x0000_8000` with `rd=1`, then `addr=0x40` with `wr=1`:
  - each gives 4 beats with `error=1`, `data=0`;
  - `mem.en` stays 0 throughout.
- Reset mid-burst: assert `rst` for 1 cycle after beat 2 handshakes.
  - All outputs are 0 on the next cycle.
  - Then a request to `0x58` returns 11, 8, 9, 10 correctly.
- Back-to-back: second request (`addr=0x20`) held valid from T+1.
  - `req.ready=0` until the cycle after the last beat of the first burst.
  - Second request accepted that cycle; returns 4, 5, 6, 7.
